// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for pipe_skid_reg: producer side, consumer side and occupancy.
// The slave modport is the register's own view of the bundle.
interface pipe_skid_reg_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output count
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  count
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register (main + skid) with a fully registered in_ready.
// Sustains one transfer per cycle with one cycle of latency.
module pipe_skid_reg #(
    parameter int unsigned WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    input logic            flush,
    pipe_skid_reg_if.slave bus
);
    // Encoding is {skid_valid, main_valid}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StBusy  = 2'b01,
        StFull  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             main_valid, skid_valid;
    logic             in_fire, out_fire;

    assign main_valid = state_q[0];
    assign skid_valid = state_q[1];

    assign bus.out_data  = main_q;
    assign bus.out_valid = main_valid;
    assign bus.in_ready  = ~skid_valid;
    assign bus.count     = {1'b0, main_valid} + {1'b0, skid_valid};

    assign in_fire  = bus.in_valid & ~skid_valid;
    assign out_fire = main_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d = StBusy;
                        main_d  = bus.in_data;
                    end
                end
                StBusy: begin
                    if (in_fire && out_fire) begin
                        main_d = bus.in_data;
                    end else if (in_fire) begin
                        state_d = StFull;
                        skid_d  = bus.in_data;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    // in_ready is low here, so only the consumer side can move.
                    if (out_fire) begin
                        state_d = StBusy;
                        main_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and scoreboard-driven bench for pipe_skid_reg.
module tb_pipe_skid_reg;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic reset;
    logic flush;
    int   n_checks;
    int   n_pass;

    pipe_skid_reg_if #(.WIDTH(WIDTH)) bus ();

    pipe_skid_reg #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] sb[$];
    logic             m_in_ready;
    logic             m_out_valid;

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        reset         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        #2;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_count", {30'd0, bus.count}, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        step();
        reset = 1'b1;
        step();

        // Streaming at full rate.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.in_data = 32'(i);
            step();
            check("stream_data", bus.out_data, 32'(i));
            check("stream_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stream_count", {30'd0, bus.count}, 32'd1);
            check("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
        end
        bus.in_valid = 1'b0;
        step();
        check("stream_drain_count", {30'd0, bus.count}, 32'd0);

        // Backpressure into the skid entry.
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h10;
        step();
        bus.out_ready = 1'b0;
        bus.in_data   = 32'h11;
        step();
        bus.in_valid = 1'b0;
        check("bp_count", {30'd0, bus.count}, 32'd2);
        check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_data", bus.out_data, 32'h10);
            check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        check("bp_first_word", bus.out_data, 32'h10);
        step();
        check("bp_second_word", bus.out_data, 32'h11);
        check("bp_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
        check("bp_count_one", {30'd0, bus.count}, 32'd1);
        step();
        check("bp_empty", {30'd0, bus.count}, 32'd0);

        // Flush while FULL: main word is delivered in the flush cycle, 0x22 never appears.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h30;
        step();
        bus.in_data = 32'h31;
        step();
        check("fl_full_count", {30'd0, bus.count}, 32'd2);
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_data   = 32'h22;
        check("fl_deliver_valid", {31'd0, bus.out_valid}, 32'd1);
        check("fl_deliver_data", bus.out_data, 32'h30);
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_count", {30'd0, bus.count}, 32'd0);
        check("fl_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("fl_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        check("fl_no_ghost", {31'd0, bus.out_valid}, 32'd0);

        // Flush discards a word accepted in the same cycle.
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h44;
        step();
        flush       = 1'b1;
        bus.in_data = 32'h55;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_busy_valid", {31'd0, bus.out_valid}, 32'd0);
        check("fl_busy_count", {30'd0, bus.count}, 32'd0);

        // Asynchronous reset mid-cycle while FULL.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hAAAA;
        step();
        bus.in_data = 32'hBBBB;
        step();
        bus.in_valid = 1'b0;
        check("ar_full_count", {30'd0, bus.count}, 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("ar_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("ar_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("ar_count", {30'd0, bus.count}, 32'd0);
        check("ar_out_data", bus.out_data, 32'd0);
        step();
        reset = 1'b1;
        step();

        // Random soak against a scoreboard FIFO, then drain.
        sb.delete();
        for (int cyc = 0; cyc < 10000 + 4; cyc++) begin
            if (cyc < 10000) begin
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.out_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b1;
            end
            bus.in_data = $urandom;
            m_in_ready  = (sb.size() < 2);
            m_out_valid = (sb.size() > 0);
            check("soak_count", {30'd0, bus.count}, 32'(sb.size()));
            check("soak_in_ready", {31'd0, bus.in_ready}, {31'd0, m_in_ready});
            check("soak_out_valid", {31'd0, bus.out_valid}, {31'd0, m_out_valid});
            if (m_out_valid) check("soak_out_data", bus.out_data, sb[0]);
            if (m_out_valid && bus.out_ready) void'(sb.pop_front());
            if (m_in_ready && bus.in_valid) sb.push_back(bus.in_data);
            step();
        end
        check("soak_drained", {30'd0, bus.count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
